half_classify: RTL and testbench
================================

Name: half_classify

Overview:
- Result-side consumer of the half-precision predictor.
- Samples the predictor's done pulse and its OUTPUT_NODES half-precision scores y[].
- Scans the captured scores sequentially, one per cycle, and reports the arg-max class index and score with a one-cycle valid pulse.
- Optionally scores the result against a supplied label, keeping running image and correct counters for accuracy measurement in MNIST test runs.

Parameters:
- OUTPUT_NODES, 10, number of half-precision scores per prediction; must be >= 1.
- CNT_W, 16, width of the image and correct counters.
- IDX_W (localparam), max(1, $clog2(OUTPUT_NODES)), width of the class index.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- done_in  in  1  one-cycle pulse from the predictor; y and label are valid in this cycle.
- y  in  [OUTPUT_NODES] x 16  half-precision scores, unpacked array.
- label  in  IDX_W  expected class for this image.
- clear_stats  in  1  synchronous clear of the counters and overrun.
- busy  out  1  high while capturing or scanning.
- valid  out  1  one-cycle pulse; class_idx, class_val and correct are valid.
- class_idx  out  IDX_W  index of the maximum score.
- class_val  out  16  half value of the maximum score.
- correct  out  1  class_idx == captured label; qualified by valid.
- image_count  out  CNT_W  number of results reported.
- correct_count  out  CNT_W  number of correct results.
- overrun  out  1  sticky; done_in arrived while SCAN was active.

Behaviour:
- Reset (rst=1 at a posedge): state=IDLE; all outputs 0, including the counters and overrun.
- rst overrides every other input, including mid-scan; the scan in progress is discarded and no valid is produced.
- States:
  - IDLE: on done_in, capture y[0..N-1] and label; best=y[0], idx=0, ptr=1. Go to SCAN, or to REPORT if N=1.
  - SCAN: compare cap[ptr] with best; replace best/idx only if cap[ptr] is strictly greater. ptr++. After comparing ptr=N-1, go to REPORT.
  - REPORT: valid=1 for exactly one cycle.
    - In this cycle: image_count+1; correct_count+1 if correct.
    - If done_in is high in the REPORT cycle, capture the new vector and go to SCAN, or stay in REPORT if N=1. Otherwise go to IDLE.
- Latency: done_in high in cycle 0 gives valid high in cycle N (cycle 10 for N=10).
- Throughput: one image per N cycles.
- busy=1 in SCAN; also 1 in IDLE/REPORT in the cycle after a capture. busy=0 in the REPORT cycle itself.
- done_in while in SCAN: ignored, capture registers unchanged, overrun set to 1.
- class_idx and class_val hold their last values until the next REPORT.
- Half compare via ordered key:
  - Canonicalise -0 (0x8000) to +0 (0x0000).
  - key = sign ? ~bits : bits | 0x8000; compare keys as unsigned.
  - NaN (exp=0x1F, mant!=0) is less than every non-NaN, including -inf. An all-NaN vector yields idx 0.
  - ±inf are ordered normally.
  - Ties keep the lower index.
- Counters saturate at 2^CNT_W-1; no wrap.
- clear_stats clears image_count, correct_count and overrun. If clear_stats coincides with a REPORT increment, clear wins: result 0.
- Scanning is not affected by clear_stats.

Decomposition:
- Package half_pkg holds:
  - typedef half_t (logic [15:0]);
  - constants HALF_POS_ZERO, HALF_NEG_ZERO, HALF_EXP_MAX;
  - functions half_is_nan and half_order_key.
- One natural sub-module: half_greater, combinational. Inputs a, b; output gt = a > b under the rules above. It is reused by later max-pool and softmax blocks.

Test Plan:
- Basic: y=[0x3800, 0x4000, 0x3C00, 0, ...], label=1, done_in pulse cycle 0 -> valid in cycle 10, class_idx=1, class_val=0x4000, correct=1, image_count=1, correct_count=1.
- Negatives, zero and ties: all y=0xBC00 except y[3]=0x8000 and y[7]=0x0000, label=7 -> class_idx=3 (-0 == +0, lower index wins), correct=0, correct_count unchanged.
- NaN and inf: y[0]=0x7E00, y[4]=0x7C00, others 0x3C00 -> class_idx=4, class_val=0x7C00. All-NaN vector -> class_idx=0, class_val=0x7E00.
- Back-to-back and overrun:
  - done_in in cycle 0 and in cycle 10 (the REPORT cycle) -> second valid in cycle 20, image_count=2, overrun=0.
  - Extra done_in in cycle 5 -> overrun=1, and the first result is unchanged.
- Reset mid-scan: rst at cycle 4 -> no valid in cycle 10, all outputs 0, state IDLE. A following done_in gives a normal result N cycles later.
- Saturation and clear:
  - Force image_count to 0xFFFF, then one more result -> stays 0xFFFF.
  - clear_stats coincident with valid -> counters 0 next cycle.

Source files
------------

// File: rtl/half_pkg.sv
// Shared half-precision helpers: ordered compare keys and NaN detection.
package half_pkg;

    typedef logic [15:0] half_t;

    localparam half_t      HALF_POS_ZERO = 16'h0000;
    localparam half_t      HALF_NEG_ZERO = 16'h8000;
    localparam logic [4:0] HALF_EXP_MAX  = 5'h1F;

    function automatic logic half_is_nan(input half_t h);
        return (h[14:10] == HALF_EXP_MAX) && (h[9:0] != '0);
    endfunction

    // Maps a non-NaN half onto an unsigned key whose order matches numeric order.
    function automatic logic [15:0] half_order_key(input half_t h);
        half_t c;
        c = (h == HALF_NEG_ZERO) ? HALF_POS_ZERO : h;
        return c[15] ? ~c : (c | 16'h8000);
    endfunction

endpackage

// File: rtl/half_greater.sv
// Combinational strict a > b for halves; NaN sorts below every non-NaN value.
module half_greater
    import half_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        gt
);

    always_comb begin
        gt = 1'b0;
        if (!half_is_nan(a)) begin
            gt = half_is_nan(b) || (half_order_key(a) > half_order_key(b));
        end
    end

endmodule

// File: rtl/half_classify.sv
// Captures predictor scores, scans them one per cycle for the arg-max and
// keeps saturating image / correct counters for accuracy runs.
module half_classify
    import half_pkg::*;
#(
    parameter  int OUTPUT_NODES = 10,
    parameter  int CNT_W        = 16,
    localparam int IDX_W        = (OUTPUT_NODES > 1) ? $clog2(OUTPUT_NODES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done_in,
    input  logic [15:0]       y [OUTPUT_NODES],
    input  logic [IDX_W-1:0]  label,
    input  logic              clear_stats,
    output logic              busy,
    output logic              valid,
    output logic [IDX_W-1:0]  class_idx,
    output logic [15:0]       class_val,
    output logic              correct,
    output logic [CNT_W-1:0]  image_count,
    output logic [CNT_W-1:0]  correct_count,
    output logic              overrun
);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    state_t             state, state_nxt;
    half_t              cap [OUTPUT_NODES];
    logic [IDX_W-1:0]   cap_label;
    half_t              best;
    logic [IDX_W-1:0]   best_idx;
    logic [IDX_W-1:0]   ptr;
    logic               cand_gt;
    logic               capture;
    logic               last;

    half_greater u_cmp (
        .a  (cap[ptr]),
        .b  (best),
        .gt (cand_gt)
    );

    assign capture = done_in && (state != SCAN);
    assign last    = (ptr == IDX_W'(OUTPUT_NODES - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (done_in) state_nxt = (OUTPUT_NODES == 1) ? REPORT : SCAN;
            SCAN:    if (last) state_nxt = REPORT;
            REPORT:  state_nxt = done_in ? ((OUTPUT_NODES == 1) ? REPORT : SCAN) : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cap_label <= '0;
            best      <= '0;
            best_idx  <= '0;
            ptr       <= '0;
            class_idx <= '0;
            class_val <= '0;
            for (int unsigned i = 0; i < OUTPUT_NODES; i++) cap[i] <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                for (int unsigned i = 0; i < OUTPUT_NODES; i++) cap[i] <= y[i];
                cap_label <= label;
                best      <= y[0];
                best_idx  <= '0;
                ptr       <= IDX_W'(1);
                if (OUTPUT_NODES == 1) begin
                    class_idx <= '0;
                    class_val <= y[0];
                end
            end else if (state == SCAN) begin
                ptr <= ptr + 1'b1;
                if (cand_gt) begin
                    best     <= cap[ptr];
                    best_idx <= ptr;
                end
                // Result registers load once so they hold steady outside REPORT.
                if (last) begin
                    class_idx <= cand_gt ? ptr : best_idx;
                    class_val <= cand_gt ? cap[ptr] : best;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_stats) begin
            image_count   <= '0;
            correct_count <= '0;
            overrun       <= 1'b0;
        end else begin
            if (state == REPORT) begin
                if (image_count != '1) image_count <= image_count + 1'b1;
                if (correct && (correct_count != '1)) correct_count <= correct_count + 1'b1;
            end
            if (done_in && (state == SCAN)) overrun <= 1'b1;
        end
    end

    assign valid   = (state == REPORT);
    assign busy    = (state == SCAN);
    assign correct = valid && (class_idx == cap_label);

endmodule

// File: tb/tb_half_classify.sv
// Self-checking bench for half_classify: directed table, multi-cycle corner
// sequences and random vectors against a real-valued arg-max model.
module tb_half_classify;

    localparam int N = 10;

    typedef logic [15:0] vec_t [N];
    typedef struct {
        vec_t        y;
        logic [3:0]  label;
        int          exp_idx;
        logic [15:0] exp_val;
        bit          exp_cor;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        done_in = 1'b0;
    logic [15:0] y_in [N];
    logic [3:0]  label_in = '0;
    logic        clear_stats = 1'b0;

    logic        busy, valid, correct, overrun;
    logic [3:0]  class_idx;
    logic [15:0] class_val, image_count, correct_count;

    logic        busy_s, valid_s, correct_s, overrun_s;
    logic [3:0]  class_idx_s;
    logic [15:0] class_val_s;
    logic [1:0]  image_count_s, correct_count_s;

    int tests = 0;
    int failed = 0;
    int img = 0;
    int cor = 0;

    half_classify #(.OUTPUT_NODES(N), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .done_in(done_in), .y(y_in), .label(label_in),
        .clear_stats(clear_stats), .busy(busy), .valid(valid), .class_idx(class_idx),
        .class_val(class_val), .correct(correct), .image_count(image_count),
        .correct_count(correct_count), .overrun(overrun)
    );

    // Narrow-counter instance sharing the same stimulus exercises saturation.
    half_classify #(.OUTPUT_NODES(N), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .done_in(done_in), .y(y_in), .label(label_in),
        .clear_stats(clear_stats), .busy(busy_s), .valid(valid_s), .class_idx(class_idx_s),
        .class_val(class_val_s), .correct(correct_s), .image_count(image_count_s),
        .correct_count(correct_count_s), .overrun(overrun_s)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_nan_h(input logic [15:0] h);
        return (h[14:10] == 5'h1F) && (h[9:0] != 10'd0);
    endfunction

    function automatic real h2r(input logic [15:0] h);
        int  e = int'(h[14:10]);
        int  m = int'(h[9:0]);
        real v;
        if (e == 31)     v = 1.0e6;
        else if (e == 0) v = m * (2.0 ** (-24));
        else             v = (1024 + m) * (2.0 ** (e - 25));
        return h[15] ? -v : v;
    endfunction

    function automatic int ref_argmax(input vec_t v);
        int b = 0;
        for (int i = 1; i < N; i++) begin
            if (!is_nan_h(v[i]) && (is_nan_h(v[b]) || h2r(v[i]) > h2r(v[b]))) b = i;
        end
        return b;
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic send(input vec_t v, input logic [3:0] lb);
        y_in     = v;
        label_in = lb;
        done_in  = 1'b1;
        tick();
        done_in  = 1'b0;
    endtask

    // Waits for the valid pulse starting at cycle `start` after the capture cycle.
    task automatic await_result(input int start, input int e_idx, input logic [15:0] e_val,
                                input bit e_cor, input string tag);
        int c = start;
        while (!valid && c < 30) begin
            tick();
            c++;
        end
        check({tag, " latency"}, c, N);
        if (valid) begin
            check({tag, " class_idx"}, class_idx, e_idx);
            check({tag, " class_val"}, class_val, e_val);
            check({tag, " correct"}, correct, e_cor);
            check({tag, " busy_in_report"}, busy, 0);
            img++;
            if (e_cor) cor++;
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, " image_count"}, image_count, min_i(img, 65535));
        check({tag, " correct_count"}, correct_count, min_i(cor, 65535));
        check({tag, " image_count_sat"}, image_count_s, min_i(img, 3));
        check({tag, " correct_count_sat"}, correct_count_s, min_i(cor, 3));
    endtask

    rec_t tbl [4];
    vec_t va, vb, vr;
    int   ri, vis;

    initial begin
        for (int i = 0; i < N; i++) y_in[i] = '0;

        for (int i = 0; i < N; i++) tbl[0].y[i] = 16'h0000;
        tbl[0].y[0] = 16'h3800; tbl[0].y[1] = 16'h4000; tbl[0].y[2] = 16'h3C00;
        tbl[0].label = 4'd1; tbl[0].exp_idx = 1; tbl[0].exp_val = 16'h4000; tbl[0].exp_cor = 1'b1;

        for (int i = 0; i < N; i++) tbl[1].y[i] = 16'hBC00;
        tbl[1].y[3] = 16'h8000; tbl[1].y[7] = 16'h0000;
        tbl[1].label = 4'd7; tbl[1].exp_idx = 3; tbl[1].exp_val = 16'h8000; tbl[1].exp_cor = 1'b0;

        for (int i = 0; i < N; i++) tbl[2].y[i] = 16'h3C00;
        tbl[2].y[0] = 16'h7E00; tbl[2].y[4] = 16'h7C00;
        tbl[2].label = 4'd4; tbl[2].exp_idx = 4; tbl[2].exp_val = 16'h7C00; tbl[2].exp_cor = 1'b1;

        for (int i = 0; i < N; i++) tbl[3].y[i] = 16'h7E00;
        tbl[3].label = 4'd0; tbl[3].exp_idx = 0; tbl[3].exp_val = 16'h7E00; tbl[3].exp_cor = 1'b1;

        tick();
        tick();
        rst = 1'b0;
        check("reset valid", valid, 0);
        check("reset busy", busy, 0);
        check("reset class_idx", class_idx, 0);
        check("reset class_val", class_val, 0);
        check("reset overrun", overrun, 0);
        check_counts("reset");

        for (int t = 0; t < 4; t++) begin
            send(tbl[t].y, tbl[t].label);
            await_result(1, tbl[t].exp_idx, tbl[t].exp_val, tbl[t].exp_cor, $sformatf("table%0d", t));
            tick();
            check_counts($sformatf("table%0d", t));
            check($sformatf("table%0d hold_idx", t), class_idx, tbl[t].exp_idx);
        end

        // Back-to-back: second done_in lands in the REPORT cycle.
        va = tbl[0].y;
        vb = tbl[2].y;
        send(va, 4'd1);
        check("b2b busy_scan", busy, 1);
        await_result(1, 1, 16'h4000, 1'b1, "b2b_first");
        y_in = vb; label_in = 4'd3; done_in = 1'b1;
        tick();
        done_in = 1'b0;
        await_result(1, 4, 16'h7C00, 1'b0, "b2b_second");
        tick();
        check_counts("b2b");
        check("b2b overrun", overrun, 0);

        // Overrun: extra done_in in cycle 5 is dropped.
        send(va, 4'd1);
        repeat (4) tick();
        y_in = vb; label_in = 4'd4; done_in = 1'b1;
        tick();
        done_in = 1'b0;
        await_result(6, 1, 16'h4000, 1'b1, "overrun_first");
        tick();
        check("overrun set", overrun, 1);
        check_counts("overrun");
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        img = 0; cor = 0;
        check("overrun cleared", overrun, 0);
        check_counts("clear");

        // Clear coincident with the REPORT increment: clear wins.
        send(tbl[2].y, 4'd4);
        await_result(1, 4, 16'h7C00, 1'b1, "clr_coinc");
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        img = 0; cor = 0;
        check_counts("clr_coinc");

        // Reset mid-scan discards the scan.
        send(va, 4'd1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        img = 0; cor = 0;
        check("midrst busy", busy, 0);
        check("midrst class_idx", class_idx, 0);
        check("midrst class_val", class_val, 0);
        check("midrst overrun", overrun, 0);
        check_counts("midrst");
        vis = 0;
        for (int i = 0; i < 10; i++) begin
            if (valid) vis++;
            tick();
        end
        check("midrst no_valid", vis, 0);
        send(tbl[2].y, 4'd4);
        await_result(1, 4, 16'h7C00, 1'b1, "after_rst");
        tick();
        check_counts("after_rst");

        // Random vectors against the real-valued reference.
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 7))
                    4:       vr[i] = 16'h3C00;
                    5:       vr[i] = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h0000;
                    6:       vr[i] = 16'h7C00 | 16'(1 + $urandom_range(0, 1022));
                    7:       vr[i] = ($urandom_range(0, 1) == 1) ? 16'hFC00 : 16'h7C00;
                    default: vr[i] = 16'($urandom);
                endcase
            end
            ri = ref_argmax(vr);
            label_in = ($urandom_range(0, 1) == 1) ? 4'(ri) : 4'($urandom_range(0, N - 1));
            send(vr, label_in);
            await_result(1, ri, vr[ri], (label_in == 4'(ri)), $sformatf("rand%0d", t));
            tick();
            check_counts($sformatf("rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
